// File: rtl/timer_counter_prs.sv
// Segment-loadable up/down timer counter with power-of-two prescaler,
// compare match, wrap detection, sticky pending flags and a maskable interrupt.
module timer_counter_prs #(
  parameter int CNT_W = 64,
  parameter int SEG_W = 32,
  parameter int DIV_W = 4,
  localparam int NSEG  = CNT_W / SEG_W,
  localparam int PRS_W = (2**DIV_W) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  input  logic             dir,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic [NSEG-1:0]  ld_sel,
  input  logic [CNT_W-1:0] ld_data,
  input  logic             cmp_en,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic             cmp_ie,
  input  logic             ovf_ie,
  input  logic             cmp_clr,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             cmp_match,
  output logic             ovf,
  output logic             cmp_pend,
  output logic             ovf_pend,
  output logic             irq
);

  logic [PRS_W-1:0] div_cnt;
  logic [PRS_W-1:0] div_term;
  logic [PRS_W-1:0] div_cnt_d;
  logic [CNT_W-1:0] cnt_load;
  logic [CNT_W-1:0] cnt_step;
  logic [CNT_W-1:0] cnt_d;
  logic             ld_any;
  logic             step;
  logic             wrap;

  // Terminal count 2**div_val-1 built as a thermometer mask of div_val ones.
  always_comb begin
    div_term = '0;
    for (int i = 0; i < PRS_W; i++) begin
      div_term[i] = (i < int'(div_val));
    end
  end

  assign tick   = cnt_en & (~div_en | (div_cnt == div_term));
  assign ld_any = |ld_sel;
  assign step   = tick & ~cnt_clr & ~ld_any;

  // Unselected segments keep their current value.
  always_comb begin
    cnt_load = cnt;
    for (int i = 0; i < NSEG; i++) begin
      if (ld_sel[i]) begin
        cnt_load[i*SEG_W +: SEG_W] = ld_data[i*SEG_W +: SEG_W];
      end
    end
  end

  always_comb begin
    cnt_step = cnt + 1'b1;
    wrap     = &cnt;
    if (dir) begin
      cnt_step = cnt - 1'b1;
      wrap     = (cnt == '0);
    end
  end

  always_comb begin
    cnt_d = cnt;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (ld_any) begin
      cnt_d = cnt_load;
    end else if (step) begin
      cnt_d = cnt_step;
    end
  end

  // The prescaler keeps running through load cycles; only a clear resets it.
  always_comb begin
    div_cnt_d = div_cnt;
    if (cnt_clr) begin
      div_cnt_d = '0;
    end else if (cnt_en && div_en) begin
      div_cnt_d = tick ? '0 : div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_cnt <= '0;
    end else begin
      cnt     <= cnt_d;
      div_cnt <= div_cnt_d;
    end
  end

  // Event pulses only come from count steps, never from loads or clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_match <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      cmp_match <= step & cmp_en & (cnt_step == cmp_val);
      ovf       <= step & wrap;
    end
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_pend <= 1'b0;
      ovf_pend <= 1'b0;
      irq      <= 1'b0;
    end else begin
      cmp_pend <= cmp_match | (cmp_pend & ~cmp_clr);
      ovf_pend <= ovf | (ovf_pend & ~ovf_clr);
      irq      <= (cmp_pend & cmp_ie) | (ovf_pend & ovf_ie);
    end
  end

endmodule
